// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter sharing one SDF FFT between two sample sources.
// Also tags each frame leaving the FFT with the id of the requester that produced it.
module fft_frame_arbiter #(
  parameter int unsigned INTEGER_SIZE = 8,
  parameter int unsigned FRACT_SIZE   = 8,
  parameter int unsigned NFFT         = 128,
  parameter int unsigned TAG_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req0,
  input  logic                                req1,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in0_r,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in0_i,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in1_r,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in1_i,
  output logic                                grant0,
  output logic                                grant1,
  output logic                                start_FFT,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  fft_in_r,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  fft_in_i,
  input  logic                                data_valid_FFT,
  output logic                                out_tag,
  output logic                                out_last,
  output logic                                tag_err
);

  localparam int unsigned DW = INTEGER_SIZE + FRACT_SIZE;
  localparam int unsigned CW = $clog2(NFFT);
  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam logic [CW-1:0] CntMax  = CW'(NFFT - 1);
  localparam logic [PW:0]   TagFull = (PW+1)'(TAG_DEPTH);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          grant0_q, grant0_d;
  logic          grant1_q, grant1_d;
  logic          start_q, start_d;
  logic          last_q, last_d;
  logic          tag_err_q, tag_err_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          tag_mem_q [TAG_DEPTH];

  logic fifo_empty, fifo_full, beat, pop, push;
  logic sel, eligible, frame_end, start_frame;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == TagFull);
  // Beats arriving with no outstanding frame are dropped, not counted.
  assign beat       = data_valid_FFT && !fifo_empty;
  assign pop        = beat && (out_cnt_q == CntMax);

  assign sel         = (req0 && req1) ? ~last_q : req1;
  assign eligible    = (req0 || req1) && (!fifo_full || pop);
  assign frame_end   = (state_q == StStream) && (in_cnt_q == CntMax);
  assign start_frame = eligible && ((state_q == StIdle) || frame_end);
  assign push        = start_frame;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    start_d  = 1'b0;
    last_d   = last_q;
    if (start_frame) begin
      state_d  = StStream;
      in_cnt_d = '0;
      grant0_d = ~sel;
      grant1_d = sel;
      start_d  = 1'b1;
      last_d   = sel;
    end else if (frame_end) begin
      state_d  = StIdle;
      in_cnt_d = '0;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
    end else if (state_q == StStream) begin
      in_cnt_d = in_cnt_q + CW'(1);
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    count_d   = count_q;
    tag_err_d = tag_err_q | (data_valid_FFT && fifo_empty);
    if (beat) begin
      out_cnt_d = pop ? '0 : out_cnt_q + CW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      tag_err_q <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      start_q   <= start_d;
      last_q    <= last_d;
      tag_err_q <= tag_err_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) tag_mem_q[i] <= 1'b0;
    end else if (push) begin
      tag_mem_q[wr_ptr_q] <= sel;
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign start_FFT = start_q;
  assign tag_err   = tag_err_q;
  assign out_last  = pop;
  assign out_tag   = fifo_empty ? 1'b0 : tag_mem_q[rd_ptr_q];
  assign fft_in_r  = grant0_q ? in0_r : (grant1_q ? in1_r : DW'(0));
  assign fft_in_i  = grant0_q ? in0_i : (grant1_q ? in1_i : DW'(0));

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Frame-level arbiter that shares one SDF FFT pipeline between two sample sources: the incoming signal (requester 0) and the reference (requester 1) of the cross-correlator. It grants whole NFFT-sample frames round-robin and drives the FFT's start pulse and serial inputs. It also tags every frame the FFT emits with the requester that produced it, so the downstream multiply stage can steer spectra. It sits between the two input buffers and the FFT input, and observes the FFT's data-valid output.

## Interface
- INTEGER_SIZE, 8, integer bits of the sample word
- FRACT_SIZE, 8, fractional bits; DW = INTEGER_SIZE+FRACT_SIZE
- NFFT, 128, frame length in samples (power of 2, ≥4)
- TAG_DEPTH, 4, depth of in-flight frame tag FIFO (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1 each  requester has a full frame ready; held high until its grant ends
- in0_r, in0_i, in1_r, in1_i  in  DW each  signed samples, sample k presented on grant cycle k
- grant0, grant1  out  1 each  high for exactly NFFT consecutive cycles per granted frame
- start_FFT  out  1  one-cycle pulse on grant cycle 0
- fft_in_r, fft_in_i  out  DW each  muxed samples of granted requester; 0 when no grant
- data_valid_FFT  in  1  FFT output sample valid
- out_tag  out  1  requester id of the frame currently leaving the FFT (FIFO head)
- out_last  out  1  high on the NFFT-th valid output beat of a frame
- tag_err  out  1  sticky: valid beat seen with tag FIFO empty

## Operation
- States: IDLE, STREAM. Counters: in_cnt (log2 NFFT bits), out_cnt (log2 NFFT bits), tag FIFO occupancy (0..TAG_DEPTH).
- Arbitration: round-robin on `last` (the id of the last granted requester). If both requesters are active, grant !last. If one is active, grant it. `last` is 0 after reset, so req1 wins the first tie.
- Eligibility to start a frame: at least one req is high AND (FIFO not full, OR a pop occurs the same cycle).
- IDLE: if eligible, the next cycle enters STREAM with grant_x=1, start_FFT=1, in_cnt=0, tag x pushed, and last=x.
- STREAM: in_cnt increments each cycle. At in_cnt==NFFT-1, arbitration is re-run using req levels sampled that cycle.
  - The current requester's req counts only if it is still high.
  - If eligible, the next frame starts with no gap: the new grant and start_FFT appear in the cycle right after.
  - Otherwise, go to IDLE.
- fft_in_r/i are combinational: the granted requester's in*_r/i, else 0.
- Output side: each data_valid_FFT beat increments out_cnt. out_last = data_valid_FFT && out_cnt==NFFT-1. out_last pops the FIFO, and out_cnt wraps to 0.
- Push and pop in the same cycle leave occupancy unchanged.
- out_tag is the FIFO head; it is 0 when the FIFO is empty.
- data_valid_FFT with the FIFO empty sets tag_err; the beat is ignored (no count, no pop). tag_err clears only on rst.
- A req dropped mid-grant is ignored: the grant always runs its full NFFT cycles.

## Timing
- Reset values: state IDLE, grant0=grant1=0, start_FFT=0, fft_in=0, in_cnt=out_cnt=0, FIFO empty, out_tag=0, out_last=0, tag_err=0, last=0.
- Reset mid-frame aborts the grant in the next cycle and flushes all tags. The FFT shares rst, so partial frames are discarded.
- Latency req→grant: 1 cycle from IDLE (req sampled at edge N, grant high at N+1). Back-to-back frames: 0 idle cycles.
- grant and start_FFT are registered. out_last and tag_err come from registered counters gated by the current data_valid_FFT; tag_err becomes visible one cycle after the offending beat.
- grant0 and grant1 are never high together. Exactly one start_FFT occurs per grant.

## Test plan
- Single request: req0 high at cycle 5, NFFT=8. Required: grant0 high cycles 6–13, start_FFT only at 6, fft_in equals in0 on those cycles, grant ends at 13. Then inject 8 valid beats: out_tag=0, out_last on beat 8, FIFO empty afterwards.
- Contention: req0 and req1 both held high from reset release. Required: grants alternate 1,0,1,0 in back-to-back NFFT blocks, start_FFT every NFFT cycles, no gap cycles, no overlap.
- FIFO full: TAG_DEPTH=2, both reqs high, no data_valid_FFT. Required: exactly 2 frames are granted, then IDLE. Asserting valid beats until the first out_last must start a new grant in the next cycle.
- Simultaneous push and pop: the final valid beat of a frame coincides with a new grant's first cycle. Required: occupancy unchanged, and out_tag advances to the next queued id.
- Error: data_valid_FFT pulsed with no frame issued. Required: tag_err=1 from the next cycle and stays high until rst; out_cnt stays 0.
- Mid-frame reset: rst asserted at in_cnt=3. Required: grant and start_FFT are 0 the next cycle, and all outputs return to reset values. A req after reset gets a clean 1-cycle-latency grant.
